// File: rtl/mips_single_cycle_if.sv
// Trace bundle for mips_single_cycle: current PC, fetched instruction,
// its opcode/funct fields and the register-file write data.
// The CPU drives it through the master modport; observers use slave.
interface mips_single_cycle_if;
    logic [31:0] pc_src;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct_src;
    logic [31:0] rfile_wd;

    modport master (output pc_src, output instr, output opcode, output funct_src, output rfile_wd);
    modport slave  (input  pc_src, input  instr, input  opcode, input  funct_src, input  rfile_wd);
endinterface

// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS subset CPU. Fetch, decode, execute, memory and
// writeback complete within one clk period. Instruction memory, data memory
// and the register file are byte/word arrays preloaded from outside and are
// never cleared by reset.
// Optional feature macro: MIPS_HILO_DIV_EN adds HI/LO registers, an unsigned
// combinational divider and the DIV/MFHI/MFLO instructions. Without it those
// funct codes are treated as unknown (no writes, PC+4).
module mips_single_cycle #(
    parameter int IMEM_BYTES = 128,
    parameter int DMEM_BYTES = 128
) (
    input  logic               clk,
    input  logic               rst,
    mips_single_cycle_if.master trc
);
    localparam int IA = $clog2(IMEM_BYTES);
    localparam int DA = $clog2(DMEM_BYTES);

    logic [7:0]  imem_array [0:IMEM_BYTES-1];
    logic [7:0]  dmem_array [0:DMEM_BYTES-1];
    logic [31:0] file_array [0:31];

    logic [31:0]   pc_r;
    logic [31:0]   pc_plus4_s;
    logic [31:0]   pc_next_s;
    logic [IA-1:0] ia_s;
    logic [31:0]   instr_s;
    logic [5:0]    opcode_s;
    logic [5:0]    funct_s;
    logic [4:0]    rs_s;
    logic [4:0]    rt_s;
    logic [4:0]    rd_s;
    logic [4:0]    shamt_s;
    logic [31:0]   imm_sx_s;
    logic [31:0]   rs_val_s;
    logic [31:0]   rt_val_s;
    logic [31:0]   br_target_s;
    logic [31:0]   jmp_target_s;
    logic [31:0]   dm_addr_s;
    logic [DA-1:0] dm_base_s;
    logic [31:0]   dm_rdata_s;
    logic          rf_we_s;
    logic [4:0]    rf_wa_s;
    logic [31:0]   rfile_wd_s;
    logic          dm_we_s;
    logic          unused_ok_s;

    // Fetch: little-endian word at PC, byte addresses wrap within the memory.
    assign ia_s       = pc_r[IA-1:0];
    assign instr_s    = {imem_array[ia_s + IA'(3)], imem_array[ia_s + IA'(2)],
                         imem_array[ia_s + IA'(1)], imem_array[ia_s]};
    assign pc_plus4_s = pc_r + 32'd4;

    assign opcode_s = instr_s[31:26];
    assign rs_s     = instr_s[25:21];
    assign rt_s     = instr_s[20:16];
    assign rd_s     = instr_s[15:11];
    assign shamt_s  = instr_s[10:6];
    assign funct_s  = instr_s[5:0];
    assign imm_sx_s = {{16{instr_s[15]}}, instr_s[15:0]};

    // Register reads are combinational; $0 always reads as zero.
    assign rs_val_s = (rs_s == 5'd0) ? 32'd0 : file_array[rs_s];
    assign rt_val_s = (rt_s == 5'd0) ? 32'd0 : file_array[rt_s];

    assign br_target_s  = pc_plus4_s + {imm_sx_s[29:0], 2'b00};
    assign jmp_target_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};

    // Data memory is word addressed: the low two address bits are dropped.
    assign dm_addr_s  = rs_val_s + imm_sx_s;
    assign dm_base_s  = {dm_addr_s[DA-1:2], 2'b00};
    assign dm_rdata_s = {dmem_array[dm_base_s + DA'(3)], dmem_array[dm_base_s + DA'(2)],
                         dmem_array[dm_base_s + DA'(1)], dmem_array[dm_base_s]};

    assign unused_ok_s = ^{dm_addr_s[31:DA], dm_addr_s[1:0], imm_sx_s[31:30]};

`ifdef MIPS_HILO_DIV_EN
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] div_q_s;
    logic [31:0] div_r_s;
    logic        hilo_we_s;

    assign div_q_s = rs_val_s / rt_val_s;
    assign div_r_s = rs_val_s % rt_val_s;

    // HI/LO capture the divider result; a zero divisor leaves them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (hilo_we_s) begin
            hi_r <= div_r_s;
            lo_r <= div_q_s;
        end
    end
`endif

    // Decode/execute: select register write, memory write and next PC.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_wa_s    = rd_s;
        rfile_wd_s = 32'd0;
        dm_we_s    = 1'b0;
        pc_next_s  = pc_plus4_s;
`ifdef MIPS_HILO_DIV_EN
        hilo_we_s  = 1'b0;
`endif
        case (opcode_s)
            6'd0: begin
                case (funct_s)
                    6'd32: begin rf_we_s = 1'b1; rfile_wd_s = rs_val_s + rt_val_s; end
                    6'd34: begin rf_we_s = 1'b1; rfile_wd_s = rs_val_s - rt_val_s; end
                    6'd36: begin rf_we_s = 1'b1; rfile_wd_s = rs_val_s & rt_val_s; end
                    6'd37: begin rf_we_s = 1'b1; rfile_wd_s = rs_val_s | rt_val_s; end
                    6'd42: begin
                        rf_we_s    = 1'b1;
                        rfile_wd_s = {31'd0, ($signed(rs_val_s) < $signed(rt_val_s))};
                    end
                    6'd0:  begin rf_we_s = 1'b1; rfile_wd_s = rt_val_s << shamt_s; end
`ifdef MIPS_HILO_DIV_EN
                    6'd16: begin rf_we_s = 1'b1; rfile_wd_s = hi_r; end
                    6'd18: begin rf_we_s = 1'b1; rfile_wd_s = lo_r; end
                    6'd27: begin
                        if (rt_val_s != 32'd0) begin
                            hilo_we_s = 1'b1;
                        end else begin
                            hilo_we_s = 1'b0;
                        end
                    end
`endif
                    default: rf_we_s = 1'b0;
                endcase
            end
            6'd35: begin rf_we_s = 1'b1; rf_wa_s = rt_s; rfile_wd_s = dm_rdata_s; end
            6'd43: dm_we_s = 1'b1;
            6'd4: begin
                if (rs_val_s == rt_val_s) begin
                    pc_next_s = br_target_s;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            6'd2: pc_next_s = jmp_target_s;
            6'd3: begin
                pc_next_s  = jmp_target_s;
                rf_we_s    = 1'b1;
                rf_wa_s    = 5'd31;
                rfile_wd_s = pc_plus4_s;
            end
            6'd10: begin
                rf_we_s    = 1'b1;
                rf_wa_s    = rt_s;
                rfile_wd_s = {31'd0, ($signed(rs_val_s) < $signed(imm_sx_s))};
            end
            default: rf_we_s = 1'b0;
        endcase
    end

    // Program counter; reset returns it to zero immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Register file write; $0 is never written and nothing commits under reset.
    always_ff @(posedge clk) begin
        if (rst && rf_we_s && (rf_wa_s != 5'd0)) begin
            file_array[rf_wa_s] <= rfile_wd_s;
        end
    end

    // Data memory store, little-endian, suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && dm_we_s) begin
            dmem_array[dm_base_s]          <= rt_val_s[7:0];
            dmem_array[dm_base_s + DA'(1)] <= rt_val_s[15:8];
            dmem_array[dm_base_s + DA'(2)] <= rt_val_s[23:16];
            dmem_array[dm_base_s + DA'(3)] <= rt_val_s[31:24];
        end
    end

    assign trc.pc_src    = pc_r;
    assign trc.instr     = instr_s;
    assign trc.opcode    = opcode_s;
    assign trc.funct_src = funct_s;
    assign trc.rfile_wd  = rfile_wd_s;
endmodule

// File: tb/tb_mips_single_cycle.sv
// Directed bench for mips_single_cycle: preloads a small program, steps it
// one instruction per clock and compares trace nets, registers and memory
// against hand-computed values. Honours MIPS_HILO_DIV_EN for DIV/MFHI/MFLO.
module tb_mips_single_cycle;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mips_single_cycle_if trc ();

    mips_single_cycle #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst),
        .trc (trc)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        dut.imem_array[addr]     = w[7:0];
        dut.imem_array[addr + 1] = w[15:8];
        dut.imem_array[addr + 2] = w[23:16];
        dut.imem_array[addr + 3] = w[31:24];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dword(input int a);
        return {dut.dmem_array[a + 3], dut.dmem_array[a + 2], dut.dmem_array[a + 1], dut.dmem_array[a]};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;

        for (int i = 0; i < 128; i++) dut.imem_array[i] = 8'h00;
        for (int i = 0; i < 128; i++) dut.dmem_array[i] = 8'h00;
        for (int i = 0; i < 32; i++) dut.file_array[i] = 32'd0;
        dut.file_array[1]  = 32'd7;
        dut.file_array[2]  = 32'd5;
        dut.file_array[7]  = 32'h10;
        dut.file_array[8]  = 32'hA1B2C3D4;
        dut.file_array[9]  = 32'd3;
        dut.file_array[11] = 32'd17;
        dut.file_array[12] = 32'd5;
        dut.file_array[15] = 32'h99;
        dut.file_array[18] = 32'h99;
        dut.file_array[19] = 32'h11;
        dut.file_array[22] = 32'h22;
        dut.file_array[23] = 32'h33;
        dut.file_array[24] = 32'h44;

        put(32'h00, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd32));       // ADD $3,$1,$2
        put(32'h04, enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'd34));       // SUB $4,$2,$1
        put(32'h08, enc_i(6'd4, 5'd0, 5'd0, 16'd2));             // BEQ $0,$0,+2
        put(32'h0C, enc_r(5'd1, 5'd1, 5'd20, 5'd0, 6'd32));      // skipped
        put(32'h10, enc_r(5'd1, 5'd1, 5'd21, 5'd0, 6'd32));      // skipped
        put(32'h14, enc_r(5'd4, 5'd1, 5'd5, 5'd0, 6'd42));       // SLT $5,$4,$1
        put(32'h18, enc_i(6'd43, 5'd7, 5'd8, 16'd4));            // SW $8,4($7)
        put(32'h1C, enc_i(6'd35, 5'd7, 5'd14, 16'd4));           // LW $14,4($7)
        put(32'h20, enc_j(6'd3, 26'h10));                        // JAL 0x10
        put(32'h40, enc_i(6'd10, 5'd13, 5'd15, 16'hFFFF));       // SLTI $15,$13,-1
        put(32'h44, enc_r(5'd0, 5'd9, 5'd6, 5'd4, 6'd0));        // SLL $6,$9,4
        put(32'h48, enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'd32));       // ADD $0,$1,$2
        put(32'h4C, 32'h0000_0000);                              // NOP
        put(32'h50, enc_i(6'd4, 5'd1, 5'd2, 16'd4));             // BEQ $1,$2 (not taken)
        put(32'h54, enc_r(5'd3, 5'd2, 5'd16, 5'd0, 6'd36));      // AND $16,$3,$2
        put(32'h58, enc_r(5'd3, 5'd2, 5'd17, 5'd0, 6'd37));      // OR  $17,$3,$2
        put(32'h5C, enc_r(5'd1, 5'd4, 5'd18, 5'd0, 6'd42));      // SLT $18,$1,$4
        put(32'h60, enc_r(5'd11, 5'd12, 5'd0, 5'd0, 6'd27));     // DIV $11,$12
        put(32'h64, enc_r(5'd0, 5'd0, 5'd19, 5'd0, 6'd16));      // MFHI $19
        put(32'h68, enc_r(5'd0, 5'd0, 5'd22, 5'd0, 6'd18));      // MFLO $22
        put(32'h6C, enc_r(5'd11, 5'd13, 5'd0, 5'd0, 6'd27));     // DIV $11,$13 (rt=0)
        put(32'h70, enc_r(5'd0, 5'd0, 5'd23, 5'd0, 6'd16));      // MFHI $23
        put(32'h74, enc_i(6'd63, 5'd1, 5'd24, 16'h1234));        // unknown opcode
        put(32'h78, enc_r(5'd1, 5'd2, 5'd24, 5'd0, 6'd1));       // unknown funct
        put(32'h7C, enc_j(6'd2, 26'd0));                         // J 0

        #12;
        chk("reset_pc", trc.pc_src, 32'd0);
        rst = 1'b1;
        chk("add_instr", trc.instr, 32'h0022_1820);
        chk("add_funct", {26'd0, trc.funct_src}, 32'd32);
        chk("add_wd", trc.rfile_wd, 32'd12);
        tick();
        chk("add_rd", dut.file_array[3], 32'd12);
        chk("pc_plus4", trc.pc_src, 32'h4);
        tick();
        chk("sub_rd", dut.file_array[4], 32'hFFFF_FFFE);
        tick();
        chk("beq_taken_pc", trc.pc_src, 32'h14);
        tick();
        chk("slt_rd", dut.file_array[5], 32'd1);
        chk("at_sw_pc", trc.pc_src, 32'h18);
        chk("sw_opcode", {26'd0, trc.opcode}, 32'd43);

        // Reset during the store: PC clears at once, the store never lands.
        rst = 1'b0;
        #1;
        chk("async_reset_pc", trc.pc_src, 32'd0);
        tick();
        chk("reset_no_sw", dword(32'h14), 32'd0);
        chk("reset_keeps_reg", dut.file_array[3], 32'd12);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rerun_pc", trc.pc_src, 32'h18);
        tick();
        chk("sw_b0", {24'd0, dut.dmem_array[8'h14]}, 32'hD4);
        chk("sw_b1", {24'd0, dut.dmem_array[8'h15]}, 32'hC3);
        chk("sw_b2", {24'd0, dut.dmem_array[8'h16]}, 32'hB2);
        chk("sw_b3", {24'd0, dut.dmem_array[8'h17]}, 32'hA1);
        chk("lw_wd", trc.rfile_wd, 32'hA1B2C3D4);
        tick();
        chk("lw_rd", dut.file_array[14], 32'hA1B2C3D4);
        chk("jal_wd", trc.rfile_wd, 32'h24);
        tick();
        chk("jal_pc", trc.pc_src, 32'h40);
        chk("jal_ra", dut.file_array[31], 32'h24);
        tick();
        chk("slti_rd", dut.file_array[15], 32'd0);
        tick();
        chk("sll_rd", dut.file_array[6], 32'd48);
        tick();
        chk("r0_zero", dut.file_array[0], 32'd0);
        tick();
        chk("nop_pc", trc.pc_src, 32'h50);
        tick();
        chk("beq_not_taken_pc", trc.pc_src, 32'h54);
        tick();
        chk("and_rd", dut.file_array[16], 32'd4);
        tick();
        chk("or_rd", dut.file_array[17], 32'd13);
        tick();
        chk("slt_signed_rd", dut.file_array[18], 32'd0);
        tick();
        tick();
`ifdef MIPS_HILO_DIV_EN
        chk("mfhi_rd", dut.file_array[19], 32'd2);
`else
        chk("mfhi_nowrite", dut.file_array[19], 32'h11);
`endif
        tick();
`ifdef MIPS_HILO_DIV_EN
        chk("mflo_rd", dut.file_array[22], 32'd3);
`else
        chk("mflo_nowrite", dut.file_array[22], 32'h22);
`endif
        tick();
        tick();
`ifdef MIPS_HILO_DIV_EN
        chk("div0_hi_kept", dut.file_array[23], 32'd2);
`else
        chk("mfhi2_nowrite", dut.file_array[23], 32'h33);
`endif
        chk("unk_op_pc", trc.pc_src, 32'h74);
        tick();
        chk("unk_op_pc4", trc.pc_src, 32'h78);
        chk("unk_op_nowrite", dut.file_array[24], 32'h44);
        tick();
        chk("unk_fn_nowrite", dut.file_array[24], 32'h44);
        chk("unk_fn_pc4", trc.pc_src, 32'h7C);
        tick();
        chk("j0_pc", trc.pc_src, 32'd0);
        chk("skip_r20", dut.file_array[20], 32'd0);
        chk("skip_r21", dut.file_array[21], 32'd0);
        chk("dmem_other", dword(32'h10), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
